// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch resolution and precise ALU exceptions
module ex_mem_stage #(
  parameter int   DW      = 32,
  parameter logic TRAP_EN = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  input  logic          alu_of,
  input  logic [DW-1:0] pc_in,
  input  logic [4:0]    rd_in,
  input  logic          reg_write_in,
  input  logic          mem_read_in,
  input  logic          mem_write_in,
  input  logic [DW-1:0] store_data_in,
  input  logic          br_eq_in,
  input  logic          br_ne_in,
  input  logic [DW-1:0] br_target_in,
  input  logic          exc_ack,
  output logic          out_valid,
  output logic [DW-1:0] result_out,
  output logic [DW-1:0] store_data_out,
  output logic [4:0]    rd_out,
  output logic          reg_write_out,
  output logic          mem_read_out,
  output logic          mem_write_out,
  output logic          br_taken,
  output logic [DW-1:0] br_target_out,
  output logic          exc_req,
  output logic [1:0]    exc_cause,
  output logic [DW-1:0] epc,
  output logic          exc_pending
);

  logic [1:0] cause;
  logic       fault;
  logic       take;

  // Only add/sub and the divide ops can trap; overflow from any other op is ignored.
  always_comb begin
    cause = 2'b00;
    case (alu_op)
      4'b0000, 4'b0001: cause = 2'b01;
      4'b1100, 4'b1101: cause = 2'b10;
      default:          cause = 2'b00;
    endcase
    fault = in_valid & alu_of & TRAP_EN & (cause != 2'b00);
    take  = in_valid & ~fault & ((br_eq_in & alu_zero) | (br_ne_in & ~alu_zero));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid      <= 1'b0;
      result_out     <= '0;
      store_data_out <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      br_taken       <= 1'b0;
      br_target_out  <= '0;
      exc_req        <= 1'b0;
      exc_cause      <= 2'b00;
      epc            <= '0;
      exc_pending    <= 1'b0;
    end else begin
      // Acknowledge first so a fault captured on the same edge overrides it.
      if (exc_ack && exc_pending) begin
        exc_pending <= 1'b0;
        exc_cause   <= 2'b00;
      end
      if (flush) begin
        out_valid     <= 1'b0;
        reg_write_out <= 1'b0;
        mem_read_out  <= 1'b0;
        mem_write_out <= 1'b0;
        br_taken      <= 1'b0;
        exc_req       <= 1'b0;
      end else if (stall) begin
        br_taken <= 1'b0;
        exc_req  <= 1'b0;
      end else begin
        out_valid      <= in_valid;
        result_out     <= alu_result;
        store_data_out <= store_data_in;
        rd_out         <= rd_in;
        reg_write_out  <= reg_write_in & ~fault;
        mem_read_out   <= mem_read_in & ~fault;
        mem_write_out  <= mem_write_in & ~fault;
        br_taken       <= take;
        br_target_out  <= br_target_in;
        exc_req        <= fault;
        // The first unacknowledged fault is kept; an ack in this cycle frees the slot.
        if (fault && (!exc_pending || exc_ack)) begin
          epc         <= pc_in;
          exc_cause   <= cause;
          exc_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed bench for ex_mem_stage (trapping and non-trapping builds)
module tb_ex_mem_stage;

  logic        clock = 1'b0;
  logic        reset, stall, flush, in_valid, alu_zero, alu_of;
  logic [3:0]  alu_op;
  logic [31:0] alu_result, pc_in, store_data_in, br_target_in;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in, br_eq_in, br_ne_in, exc_ack;

  logic        out_valid, reg_write_out, mem_read_out, mem_write_out, br_taken, exc_req, exc_pending;
  logic [31:0] result_out, store_data_out, br_target_out, epc;
  logic [4:0]  rd_out;
  logic [1:0]  exc_cause;

  logic        out_valid_t0, reg_write_out_t0, mem_read_out_t0, mem_write_out_t0, br_taken_t0;
  logic        exc_req_t0, exc_pending_t0;
  logic [31:0] result_out_t0, store_data_out_t0, br_target_out_t0, epc_t0;
  logic [4:0]  rd_out_t0;
  logic [1:0]  exc_cause_t0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ex_mem_stage #(.DW(32), .TRAP_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero), .alu_of(alu_of),
    .pc_in(pc_in), .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .store_data_in(store_data_in), .br_eq_in(br_eq_in),
    .br_ne_in(br_ne_in), .br_target_in(br_target_in), .exc_ack(exc_ack),
    .out_valid(out_valid), .result_out(result_out), .store_data_out(store_data_out),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .br_taken(br_taken), .br_target_out(br_target_out),
    .exc_req(exc_req), .exc_cause(exc_cause), .epc(epc), .exc_pending(exc_pending)
  );

  ex_mem_stage #(.DW(32), .TRAP_EN(1'b0)) dut_t0 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero), .alu_of(alu_of),
    .pc_in(pc_in), .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .store_data_in(store_data_in), .br_eq_in(br_eq_in),
    .br_ne_in(br_ne_in), .br_target_in(br_target_in), .exc_ack(exc_ack),
    .out_valid(out_valid_t0), .result_out(result_out_t0), .store_data_out(store_data_out_t0),
    .rd_out(rd_out_t0), .reg_write_out(reg_write_out_t0), .mem_read_out(mem_read_out_t0),
    .mem_write_out(mem_write_out_t0), .br_taken(br_taken_t0), .br_target_out(br_target_out_t0),
    .exc_req(exc_req_t0), .exc_cause(exc_cause_t0), .epc(epc_t0), .exc_pending(exc_pending_t0)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    in_valid = 0; alu_op = 4'b0010; alu_result = 0; alu_zero = 0; alu_of = 0;
    pc_in = 0; rd_in = 0; reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
    store_data_in = 0; br_eq_in = 0; br_ne_in = 0; br_target_in = 0;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; exc_ack = 0;
    idle();
    // reset held two cycles
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_result", result_out, 0);
    chk("rst_ctrl", {29'b0, reg_write_out, mem_read_out, mem_write_out}, 0);
    chk("rst_br_exc", {30'b0, br_taken, exc_req}, 0);
    chk("rst_epc", epc, 0);
    chk("rst_cause_pend", {29'b0, exc_cause, exc_pending}, 0);
    reset = 0;

    // add 5+7
    in_valid = 1; alu_op = 4'b0000; alu_result = 12; rd_in = 3; reg_write_in = 1;
    tick();
    chk("add_result", result_out, 12);
    chk("add_rd", {27'b0, rd_out}, 3);
    chk("add_rw_valid", {30'b0, reg_write_out, out_valid}, 32'b11);
    chk("add_exc_req", {31'b0, exc_req}, 0);

    // overflow on add at 0x40
    alu_of = 1; pc_in = 32'h40;
    tick();
    chk("ovf_rw", {31'b0, reg_write_out}, 0);
    chk("ovf_valid", {31'b0, out_valid}, 1);
    chk("ovf_req", {31'b0, exc_req}, 1);
    chk("ovf_cause", {30'b0, exc_cause}, 1);
    chk("ovf_epc", epc, 32'h40);
    chk("ovf_pending", {31'b0, exc_pending}, 1);
    chk("t0_ovf_rw", {31'b0, reg_write_out_t0}, 1);
    chk("t0_ovf_exc", {30'b0, exc_req_t0, exc_pending_t0}, 0);

    idle();
    tick();
    chk("idle_req_drop", {31'b0, exc_req}, 0);
    chk("idle_pending", {31'b0, exc_pending}, 1);

    // second fault before ack keeps the first
    in_valid = 1; alu_op = 4'b1100; alu_of = 1; pc_in = 32'h44; reg_write_in = 1;
    tick();
    chk("f2_req", {31'b0, exc_req}, 1);
    chk("f2_epc", epc, 32'h40);
    chk("f2_cause", {30'b0, exc_cause}, 1);
    chk("f2_rw", {31'b0, reg_write_out}, 0);

    // ack and new fault together: new fault wins
    alu_op = 4'b1101; pc_in = 32'h80; exc_ack = 1;
    tick();
    chk("ackf_pending", {31'b0, exc_pending}, 1);
    chk("ackf_epc", epc, 32'h80);
    chk("ackf_cause", {30'b0, exc_cause}, 2);
    chk("ackf_req", {31'b0, exc_req}, 1);

    idle();
    tick();
    chk("ack_pending", {31'b0, exc_pending}, 0);
    chk("ack_cause", {30'b0, exc_cause}, 0);
    chk("ack_epc", epc, 32'h80);
    exc_ack = 0;

    // alu_of on a non-trapping op is not a fault
    in_valid = 1; alu_op = 4'b0010; alu_of = 1; reg_write_in = 1;
    tick();
    chk("of_other_rw", {31'b0, reg_write_out}, 1);
    chk("of_other_exc", {30'b0, exc_req, exc_pending}, 0);

    // branches
    idle();
    in_valid = 1; br_eq_in = 1; alu_zero = 1; br_target_in = 32'h100;
    tick();
    chk("beq_z1", {31'b0, br_taken}, 1);
    chk("beq_target", br_target_out, 32'h100);
    alu_zero = 0;
    tick();
    chk("beq_z0", {31'b0, br_taken}, 0);
    br_eq_in = 0; br_ne_in = 1;
    tick();
    chk("bne_z0", {31'b0, br_taken}, 1);
    chk("bne_target", br_target_out, 32'h100);
    br_eq_in = 1; br_ne_in = 1; alu_zero = 1;
    tick();
    chk("both_taken", {31'b0, br_taken}, 1);
    br_eq_in = 0; alu_zero = 0; alu_of = 1; alu_op = 4'b0001; pc_in = 32'h90; alu_result = 32'h77;
    tick();
    chk("bne_fault_br", {31'b0, br_taken}, 0);
    chk("bne_fault_epc", epc, 32'h90);
    chk("bne_fault_req", {31'b0, exc_req}, 1);

    // stall over a faulting capture attempt
    stall = 1; alu_op = 4'b0000; pc_in = 32'hA0; alu_result = 32'h55; br_eq_in = 1; alu_zero = 1;
    reg_write_in = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) exc_ack = 1;
      tick();
      chk("stall_result", result_out, 32'h77);
      chk("stall_req_br", {30'b0, exc_req, br_taken}, 0);
      chk("stall_valid", {31'b0, out_valid}, 1);
      chk("stall_epc", epc, 32'h90);
    end
    chk("stall_ack_pending", {31'b0, exc_pending}, 0);
    exc_ack = 0;

    flush = 1;
    tick();
    chk("flush_valid", {31'b0, out_valid}, 0);
    chk("flush_ctrl", {28'b0, reg_write_out, mem_read_out, mem_write_out, exc_req}, 0);
    chk("flush_epc", epc, 32'h90);
    stall = 0; flush = 0;

    idle();
    in_valid = 1; alu_result = 32'h33; reg_write_in = 1; mem_write_in = 1; store_data_in = 32'hDEAD;
    tick();
    chk("resume_result", result_out, 32'h33);
    chk("resume_store", store_data_out, 32'hDEAD);
    chk("resume_mw", {31'b0, mem_write_out}, 1);

    // reset edge with a fault presented: no pulse, state lost
    alu_op = 4'b0000; alu_of = 1; pc_in = 32'hC0; reset = 1;
    tick();
    chk("rst_mid_req", {31'b0, exc_req}, 0);
    chk("rst_mid_pend_epc", epc | {31'b0, exc_pending}, 0);
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
